// File: rtl/spi_pkg.sv
// Shared definitions for the Wishbone SPI master: register map, bit
// positions inside STATUS/CONTROL, and the shift engine state encoding.
package spi_pkg;

  localparam int unsigned REG_DATA    = 32'h00;
  localparam int unsigned REG_STATUS  = 32'h01;
  localparam int unsigned REG_CONTROL = 32'h02;
  localparam int unsigned REG_DIVIDER = 32'h03;
  localparam int unsigned REG_CS      = 32'h04;

  localparam int STAT_BUSY = 0;
  localparam int STAT_RXV  = 1;
  localparam int STAT_OVR  = 2;

  localparam int CTRL_CPOL = 0;
  localparam int CTRL_CPHA = 1;
  localparam int CTRL_LSB  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Byte shift engine: SCLK divider, 16-edge sequencer and TX/RX shifting
// for all four SPI modes with selectable bit order.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           tx,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsb_first,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 miso,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rx,
  output logic                 sclk,
  output logic                 mosi
);

  spi_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_cnt;
  logic [3:0]           edge_cnt;
  logic [7:0]           tx_q, rx_sr;
  logic                 cpha_q, lsb_q;
  logic                 edge_tick, sample, drive;
  logic [4:0]           nxt_k;
  logic [2:0]           bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    edge_tick = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (div_cnt == div_q) begin
                  edge_tick = 1'b1;
                  if (edge_cnt == 4'd15) state_d = ST_DONE;
                end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sampling edges are the even-indexed ones for CPHA=0, odd for CPHA=1;
  // the other edges present the next bit, except the final CPHA=0 edge.
  assign sample  = edge_tick && (edge_cnt[0] == cpha_q);
  assign nxt_k   = (5'(edge_cnt) + 5'd1) >> 1;
  assign drive   = edge_tick && !sample && (nxt_k != 5'd8);
  assign bit_idx = lsb_q ? nxt_k[2:0] : (3'd7 - nxt_k[2:0]);

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_q     <= '0;
      rx_sr    <= '0;
      rx       <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sclk <= cpol;
          if (start) begin
            tx_q     <= tx;
            div_q    <= div;
            cpha_q   <= cpha;
            lsb_q    <= lsb_first;
            div_cnt  <= '0;
            edge_cnt <= '0;
            if (!cpha) mosi <= lsb_first ? tx[0] : tx[7];
          end
        end
        ST_SHIFT: begin
          if (edge_tick) begin
            div_cnt  <= '0;
            edge_cnt <= edge_cnt + 4'd1;
            sclk     <= ~sclk;
            if (sample) rx_sr <= lsb_q ? {miso, rx_sr[7:1]} : {rx_sr[6:0], miso};
            if (drive)  mosi  <= tx_q[bit_idx];
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DONE: rx <= rx_sr;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_wb.sv
// Wishbone-attached SPI master: byte register window, single-cycle ack,
// chip-select control, and a shift engine for the serial side.
module spi_master_wb
  import spi_pkg::*;
#(
  parameter int NUM_CS     = 2,
  parameter int DIV_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_reset_ni,
  input  logic                  wb_strobe_i,
  input  logic                  wb_write_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [7:0]            wb_data_i,
  output logic [7:0]            wb_data_o,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  input  logic                  spi_miso,
  output logic                  spi_mosi,
  output logic                  spi_clk,
  output logic [NUM_CS-1:0]     spi_cs_n
);

  logic [31:0]          addr;
  logic                 wr, rd, start, busy, done;
  logic [2:0]           ctrl_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [NUM_CS-1:0]    cs_q;
  logic                 rxv_q, ovr_q;
  logic [7:0]           rx_byte, rd_mux;

  assign addr       = 32'(wb_addr_i);
  assign wr         = wb_strobe_i && wb_write_i;
  assign rd         = wb_strobe_i && !wb_write_i;
  assign start      = wr && (addr == REG_DATA) && !busy;
  assign wb_stall_o = 1'b0;
  assign spi_cs_n   = ~cs_q;

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      REG_DATA:    rd_mux = rx_byte;
      REG_STATUS: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_RXV]  = rxv_q;
        rd_mux[STAT_OVR]  = ovr_q;
      end
      REG_CONTROL: rd_mux = {5'd0, ctrl_q};
      REG_DIVIDER: rd_mux = 8'(div_q);
      REG_CS:      rd_mux = 8'(cs_q);
      default:     rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= 8'h00;
      ctrl_q    <= '0;
      div_q     <= DIV_WIDTH'(3);
      cs_q      <= '0;
      rxv_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      wb_ack_o  <= wb_strobe_i;
      wb_data_o <= rd ? rd_mux : 8'h00;
      // Configuration is frozen while a byte is on the wire.
      if (wr && !busy) begin
        case (addr)
          REG_CONTROL: ctrl_q <= wb_data_i[2:0];
          REG_DIVIDER: div_q  <= wb_data_i[DIV_WIDTH-1:0];
          REG_CS:      cs_q   <= wb_data_i[NUM_CS-1:0];
          default: ;
        endcase
      end
      if (wr && (addr == REG_DATA) && busy)                          ovr_q <= 1'b1;
      else if (wr && (addr == REG_STATUS) && wb_data_i[STAT_OVR])    ovr_q <= 1'b0;
      // A completing transfer beats a concurrent DATA read.
      if (done)                          rxv_q <= 1'b1;
      else if (rd && (addr == REG_DATA)) rxv_q <= 1'b0;
    end
  end

  spi_shift_engine #(.DIV_WIDTH(DIV_WIDTH)) u_engine (
    .clk       (wb_clk_i),
    .rst_n     (wb_reset_ni),
    .start     (start),
    .tx        (wb_data_i),
    .cpol      (ctrl_q[CTRL_CPOL]),
    .cpha      (ctrl_q[CTRL_CPHA]),
    .lsb_first (ctrl_q[CTRL_LSB]),
    .div       (div_q),
    .miso      (spi_miso),
    .busy      (busy),
    .done      (done),
    .rx        (rx_byte),
    .sclk      (spi_clk),
    .mosi      (spi_mosi)
  );

endmodule

// File: tb/tb_spi_master_wb.sv
// Bench for spi_master_wb: bus-level stimulus against a behavioural SPI
// slave and a byte-level expectation model.
module tb_spi_master_wb;

  localparam int NUM_CS = 2;

  logic              wb_clk_i = 1'b0;
  logic              wb_reset_ni;
  logic              wb_strobe_i, wb_write_i;
  logic [4:0]        wb_addr_i;
  logic [7:0]        wb_data_i, wb_data_o;
  logic              wb_ack_o, wb_stall_o;
  logic              spi_miso, spi_mosi, spi_clk;
  logic [NUM_CS-1:0] spi_cs_n;

  int checks = 0;
  int errors = 0;

  // slave model state
  logic       loopback = 1'b0;
  logic       armed = 1'b0;
  logic       slave_miso = 1'b0;
  logic [7:0] slv_byte;
  logic       slv_cpha, slv_lsb;
  logic [7:0] mosi_rec;
  int         edges, rises, nsamp;

  assign spi_miso = loopback ? spi_mosi : slave_miso;

  always #5 wb_clk_i = ~wb_clk_i;

  spi_master_wb #(.NUM_CS(NUM_CS), .DIV_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_reset_ni (wb_reset_ni),
    .wb_strobe_i (wb_strobe_i),
    .wb_write_i  (wb_write_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .wb_data_o   (wb_data_o),
    .wb_ack_o    (wb_ack_o),
    .wb_stall_o  (wb_stall_o),
    .spi_miso    (spi_miso),
    .spi_mosi    (spi_mosi),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n)
  );

  function automatic logic bitk(input logic [7:0] b, input int k, input logic lsb);
    return lsb ? b[k] : b[7-k];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural slave: on each master sampling edge, record MOSI and
  // present the next bit of the slave byte.
  always @(spi_clk) begin
    if (armed) begin
      edges++;
      if (spi_clk) rises++;
      if (((edges % 2) == 1) == (slv_cpha == 1'b0)) begin
        if (nsamp < 8) mosi_rec[nsamp] = spi_mosi;
        nsamp++;
        if (nsamp < 8) slave_miso = bitk(slv_byte, nsamp, slv_lsb);
      end
    end
  end

  task automatic wb_cyc(input logic we, input logic [4:0] a, input logic [7:0] d,
                        output logic [7:0] q, output logic ak);
    wb_strobe_i = 1'b1; wb_write_i = we; wb_addr_i = a; wb_data_i = d;
    @(posedge wb_clk_i); #1;
    wb_strobe_i = 1'b0; wb_write_i = 1'b0;
    q  = wb_data_o;
    ak = wb_ack_o;
  endtask

  task automatic wb_w(input logic [4:0] a, input logic [7:0] d);
    logic [7:0] q; logic ak;
    wb_cyc(1'b1, a, d, q, ak);
  endtask

  task automatic wb_r(input logic [4:0] a, output logic [7:0] q);
    logic ak;
    wb_cyc(1'b0, a, 8'h00, q, ak);
  endtask

  // Poll STATUS every cycle until BUSY drops; returns the busy-cycle count
  // and the first non-busy STATUS value.
  task automatic wait_idle(output int nbusy, output logic [7:0] st);
    logic [7:0] q; logic ak;
    nbusy = 0; st = 8'hFF;
    for (int i = 0; i < 3000; i++) begin
      wb_cyc(1'b0, 5'h01, 8'h00, q, ak);
      if (q[0]) nbusy++;
      else begin st = q; return; end
    end
    chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic arm(input logic [7:0] sb, input logic [2:0] ctrl);
    slv_byte = sb; slv_cpha = ctrl[1]; slv_lsb = ctrl[2];
    edges = 0; rises = 0; nsamp = 0; mosi_rec = 8'h00;
    slave_miso = bitk(sb, 0, ctrl[2]);
    armed = 1'b1;
  endtask

  task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] sb,
                      input logic [2:0] ctrl, input logic [7:0] dv, input logic lb);
    logic [7:0] q, exp_mosi;
    int nbusy;
    wb_w(5'h02, {5'd0, ctrl});
    wb_w(5'h03, dv);
    wb_w(5'h04, 8'h01);
    chk({tag, "_idle_clk"}, spi_clk, ctrl[0]);
    chk({tag, "_cs_n"}, spi_cs_n, 2'b10);
    loopback = lb;
    arm(lb ? tx : sb, ctrl);
    wb_w(5'h00, tx);
    wait_idle(nbusy, q);
    armed = 1'b0;
    for (int k = 0; k < 8; k++) exp_mosi[k] = bitk(tx, k, ctrl[2]);
    chk({tag, "_busy_cycles"}, nbusy, 16 * (dv + 1) + 1);
    chk({tag, "_status_done"}, q, 8'h02);
    chk({tag, "_mosi_seq"}, mosi_rec, exp_mosi);
    chk({tag, "_rises"}, rises, 8);
    chk({tag, "_end_clk"}, spi_clk, ctrl[0]);
    wb_r(5'h00, q);
    chk({tag, "_rx"}, q, lb ? tx : sb);
    wb_r(5'h01, q);
    chk({tag, "_status_clr"}, q, 8'h00);
    loopback = 1'b0;
  endtask

  initial begin
    logic [7:0] q;
    logic ak;
    int nbusy;
    wb_strobe_i = 1'b0; wb_write_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    wb_reset_ni = 1'b0;
    #1;
    chk("rst_cs_n", spi_cs_n, 2'b11);
    chk("rst_clk", spi_clk, 1'b0);
    chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_ack", wb_ack_o, 1'b0);
    chk("rst_dout", wb_data_o, 8'h00);
    repeat (3) @(posedge wb_clk_i);
    #1 wb_reset_ni = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_r(5'h01, q); chk("rst_status", q, 8'h00);
    wb_r(5'h02, q); chk("rst_control", q, 8'h00);
    wb_r(5'h03, q); chk("rst_divider", q, 8'h03);
    wb_r(5'h04, q); chk("rst_cs", q, 8'h00);

    xfer("mode0_loop", 8'hA5, 8'h00, 3'b000, 8'd1, 1'b1);
    xfer("mode3_lsb", 8'h96, 8'h3C, 3'b111, 8'd2, 1'b0);

    // overrun: second DATA write and a CS write while busy are dropped
    wb_w(5'h02, 8'h00); wb_w(5'h03, 8'h01); wb_w(5'h04, 8'h01);
    arm(8'h5A, 3'b000);
    wb_w(5'h00, 8'h11);
    wb_w(5'h00, 8'h22);
    wb_w(5'h04, 8'h02);
    wb_r(5'h04, q); chk("ovr_cs_kept", q, 8'h01);
    chk("ovr_cs_pins", spi_cs_n, 2'b10);
    wait_idle(nbusy, q);
    armed = 1'b0;
    chk("ovr_status", q, 8'h06);
    chk("ovr_mosi", mosi_rec, 8'h88); // 0x11 MSB-first, bit k stored at index k
    wb_r(5'h00, q); chk("ovr_rx", q, 8'h5A);
    wb_w(5'h01, 8'h04);
    wb_r(5'h01, q); chk("ovr_clear", q, 8'h00);

    // unmapped address: zero data, one-cycle ack, writes ignored
    @(posedge wb_clk_i); #1;
    wb_strobe_i = 1'b1; wb_write_i = 1'b0; wb_addr_i = 5'h1F;
    chk("unmap_ack_pre", wb_ack_o, 1'b0);
    @(posedge wb_clk_i); #1;
    wb_strobe_i = 1'b0;
    chk("unmap_ack", wb_ack_o, 1'b1);
    chk("unmap_data", wb_data_o, 8'h00);
    @(posedge wb_clk_i); #1;
    chk("unmap_ack_post", wb_ack_o, 1'b0);
    wb_w(5'h1F, 8'hFF);
    wb_r(5'h02, q); chk("unmap_w_ctrl", q, 8'h00);
    wb_r(5'h03, q); chk("unmap_w_div", q, 8'h01);
    wb_r(5'h04, q); chk("unmap_w_cs", q, 8'h01);
    wb_r(5'h01, q); chk("unmap_w_status", q, 8'h00);

    for (int i = 0; i < 6; i++) begin
      xfer($sformatf("rand%0d", i), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 3)), 1'b0);
    end

    // reset after the 4th SCLK edge
    wb_w(5'h02, 8'h00); wb_w(5'h03, 8'h03); wb_w(5'h04, 8'h01);
    arm(8'hC3, 3'b000);
    wb_w(5'h00, 8'hFF);
    for (int i = 0; i < 500 && edges < 4; i++) begin
      @(posedge wb_clk_i); #1;
    end
    chk("rstmid_reached", (edges >= 4), 1'b1);
    armed = 1'b0;
    #2 wb_reset_ni = 1'b0;
    #1;
    chk("rstmid_cs_n", spi_cs_n, 2'b11);
    chk("rstmid_clk", spi_clk, 1'b0);
    chk("rstmid_mosi", spi_mosi, 1'b0);
    @(posedge wb_clk_i); #1 wb_reset_ni = 1'b1;
    wb_r(5'h01, q); chk("rstmid_status", q, 8'h00);
    wb_r(5'h00, q); chk("rstmid_rx", q, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_wb.md
# spi_master_wb

Parametrised, Wishbone-attached SPI master that replaces the stubbed SPI controller. It provides a byte-wide register window for data, status, mode, clock divider and chip-select control. A shift engine runs all four SPI modes with selectable bit order and a programmable SCLK rate. It drives NUM_CS active-low chip selects, for example SD card and RTC.

## Interface
Parameters:
- NUM_CS, 2, number of chip-select outputs (1..8)
- DIV_WIDTH, 8, width of the DIVIDER register (≤8)
- ADDR_WIDTH, 5, Wishbone address width

Ports:
- wb_clk_i  in  1  single clock for the whole block
- wb_reset_ni  in  1  reset, asynchronous assert, active-low
- wb_strobe_i  in  1  transaction valid
- wb_write_i  in  1  1 = write
- wb_addr_i  in  ADDR_WIDTH  register address
- wb_data_i  in  8  write data
- wb_data_o  out  8  read data, valid with ack
- wb_ack_o  out  1  acknowledge
- wb_stall_o  out  1  tied 0
- spi_miso  in  1  serial in
- spi_mosi  out  1  serial out
- spi_clk  out  1  SCLK
- spi_cs_n  out  NUM_CS  chip selects, active-low

## Operation
Registers (unmapped addresses read 0x00, writes ignored):
- 0x00 DATA
  - Write while idle: loads TX, starts a transfer.
  - Write while busy: dropped, sets OVR.
  - Read: returns last RX byte, clears RXV.
- 0x01 STATUS
  - bit0 BUSY (read-only), bit1 RXV, bit2 OVR.
  - Writing 1 to bit2 clears OVR.
- 0x02 CONTROL
  - bit0 CPOL, bit1 CPHA, bit2 LSB_FIRST; reset 0x00.
- 0x03 DIVIDER
  - SCLK half-period = DIVIDER+1 clocks; reset 0x03.
- 0x04 CS
  - bit i = 1 drives spi_cs_n[i] low; reset 0x00.
  - Bits ≥ NUM_CS read 0.
- Writes to CONTROL, DIVIDER and CS while BUSY are ignored, and OVR is not set.

Shift engine FSM:
- IDLE -> SHIFT on an accepted DATA write: latch TX, CONTROL and DIVIDER.
- SHIFT: 16 half-periods; edge counter 0..15.
  - CPHA=0: first bit on MOSI at SHIFT entry; sample MISO on odd-numbered edges (1st, 3rd, …); shift on even edges.
  - CPHA=1: shift on the 1st edge, sample on the 2nd, alternating.
- SHIFT -> DONE after the 16th edge.
- DONE: store RX, set RXV, -> IDLE.
- Bit order follows LSB_FIRST; default is MSB first.
- SCLK idles at CPOL. MOSI holds its last bit in IDLE.

Boundary rules:
- RXV set (DONE) and DATA read in the same cycle: set wins; the read returns the previous RX byte.
- A DATA write in the DONE cycle sees BUSY=1: it is an overrun.
- Reset mid-transfer: transfer aborted, all outputs take their reset values immediately, no RX update.
- MISO is sampled with no synchronizer.

## Timing
- Wishbone: ack registered, one cycle after strobe. Read data is registered with ack. No stalls.
- BUSY reads 1 starting the cycle after the DATA write strobe.
- The first SCLK edge occurs DIVIDER+1 clocks after SHIFT entry.
- A transfer holds BUSY for 16·(DIVIDER+1)+1 clocks.
- RXV and the RX data are visible to a read strobed in the cycle after DONE.
- Reset values:
  - wb_ack_o 0, wb_data_o 0x00
  - spi_clk 0, spi_mosi 0, spi_cs_n all 1
  - FSM IDLE, RXV/OVR 0

## Structure
- Package spi_pkg holds:
  - register address localparams (DATA, STATUS, CONTROL, DIVIDER, CS)
  - STATUS and CONTROL bit indexes
  - state enum (IDLE, SHIFT, DONE)
- Sub-module spi_shift_engine contains the divider counter, edge counter, FSM, and TX/RX shift registers.
  - Inputs: start, tx byte, mode bits, divider.
  - Outputs: busy, done pulse, rx byte, SCLK/MOSI.
- The top level holds the register file, Wishbone handshake and CS logic.

## Test plan
- Reset:
  - Release wb_reset_ni, read each register -> STATUS 0x00, CONTROL 0x00, DIVIDER 0x03, CS 0x00.
  - Pins: spi_cs_n all 1, spi_clk 0.
- Mode 0 loopback:
  - Setup: MISO tied to MOSI, DIVIDER=1, CS=0x01.
  - Write DATA 0xA5 -> spi_cs_n=2'b10, 8 rising edges, MOSI sequence 1,0,1,0,0,1,0,1.
  - BUSY high for 33 cycles, then STATUS=0x02 and DATA read 0xA5.
  - A second STATUS read returns 0x00.
- Mode 3 LSB-first:
  - Setup: CONTROL=0x07, model drives 0x3C on MISO.
  - SCLK idles high; RX reads 0x3C; MOSI carries TX LSB first.
- Overrun:
  - Write DATA 0x11, then 0x22 while busy -> only 0x11 is shifted, STATUS bit2=1.
  - Write STATUS 0x04 -> bit2 clears.
  - A CS write while busy leaves CS unchanged.
- Reset mid-transfer: drive wb_reset_ni low after the 4th SCLK edge -> same cycle: spi_cs_n all 1, spi_clk 0, BUSY 0; RX stays 0x00.
- Unmapped address 0x1F: read -> 0x00 with ack exactly one cycle after strobe. A write has no effect.
